brick_grid: RTL and testbench

Parametrised brick-field store for the Arkanoid playfield, holding one KIND_W-bit brick kind per cell for a ROWS x COLS grid. It adds multi-hit bricks, indestructible bricks, a live remaining-brick count, a destroy strobe and multi-cycle row-sweep operations: stage load, drop-down and pull-up. It sits between the ball/collision logic, which issues WRITE and HIT, and the game controller, which issues LOAD, DROP and PULL. The renderer reads it through row/col/out.

---
 rtl/brick_grid_pkg.sv | 35 +++
 rtl/brick_stage_rom.sv | 22 ++
 rtl/brick_grid.sv | 209 ++++++++++++++++++++
 tb/tb_brick_grid.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/brick_grid_pkg.sv
// Shared definitions for the brick field: command codes, sweep states, kind constants
// and the built-in stage pattern.
package brick_grid_pkg;

    localparam logic [3:0] FN_NOP   = 4'b0000;
    localparam logic [3:0] FN_WRITE = 4'b0011;
    localparam logic [3:0] FN_LOAD  = 4'b0101;
    localparam logic [3:0] FN_DROP  = 4'b0111;
    localparam logic [3:0] FN_PULL  = 4'b1001;
    localparam logic [3:0] FN_HIT   = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT_DN,
        ST_SHIFT_UP
    } state_t;

    localparam int unsigned KIND_EMPTY = 0;

    function automatic int unsigned kind_solid(input int unsigned kind_w);
        return (32'd1 << kind_w) - 32'd1;
    endfunction

    // Upper half of the field is filled with a per-row kind, never empty nor solid.
    function automatic int unsigned stage_kind(input int unsigned stage,
                                               input int unsigned row,
                                               input int unsigned rows,
                                               input int unsigned stages,
                                               input int unsigned kind_w);
        if (stage >= stages || row >= rows / 32'd2) return KIND_EMPTY;
        return ((row + stage) % ((32'd1 << kind_w) - 32'd2)) + 32'd1;
    endfunction

endpackage

// File: rtl/brick_stage_rom.sv
// Combinational stage pattern: one full row of brick kinds for a given stage and row.
module brick_stage_rom
    import brick_grid_pkg::*;
#(
    parameter int unsigned ROWS   = 8,
    parameter int unsigned COLS   = 16,
    parameter int unsigned KIND_W = 4,
    parameter int unsigned STAGES = 4
) (
    input  logic [KIND_W-1:0]        stage,
    input  logic [$clog2(ROWS)-1:0]  row,
    output logic [COLS*KIND_W-1:0]   pattern
);

    logic [KIND_W-1:0] kind;

    always_comb begin
        kind    = KIND_W'(stage_kind(32'(stage), 32'(row), ROWS, STAGES, KIND_W));
        pattern = {COLS{kind}};
    end

endmodule

// File: rtl/brick_grid.sv
// Brick field store with single-cycle WRITE/HIT and multi-cycle LOAD/DROP/PULL row sweeps.
// Define GRID_SCORE_EN to add a saturating score output driven by HIT.
module brick_grid
    import brick_grid_pkg::*;
#(
    parameter int unsigned ROWS   = 8,
    parameter int unsigned COLS   = 16,
    parameter int unsigned KIND_W = 4,
    parameter int unsigned STAGES = 4
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [$clog2(ROWS)-1:0]          row,
    input  logic [$clog2(COLS)-1:0]          col,
    input  logic [3:0]                       func,
    input  logic [KIND_W-1:0]                in,
    output logic [KIND_W-1:0]                out,
    output logic                             busy,
    output logic [$clog2(ROWS*COLS+1)-1:0]   remaining,
    output logic                             destroyed
`ifdef GRID_SCORE_EN
    ,
    output logic [15:0]                      score
`endif
);

    localparam int unsigned RW    = $clog2(ROWS);
    localparam int unsigned REM_W = $clog2(ROWS*COLS+1);
    localparam logic [KIND_W-1:0] K_SOLID = KIND_W'(kind_solid(KIND_W));

    typedef logic [COLS-1:0][KIND_W-1:0] row_t;

    row_t [ROWS-1:0]    grid;
    state_t             state_q, state_d;
    logic [RW-1:0]      cnt_q, cnt_d;
    logic [REM_W-1:0]   acc_q, acc_d;
    logic [KIND_W-1:0]  stage_q, stage_d;
    logic [REM_W-1:0]   rem_d;
    logic               destroyed_d;
    logic               addr_ok;
    logic [KIND_W-1:0]  cell_old, cell_new;
    logic               cell_we, row_we;
    logic [RW-1:0]      row_idx;
    row_t               row_data;
    logic [COLS*KIND_W-1:0] rom_row;
`ifdef GRID_SCORE_EN
    logic [3:0]         score_inc;
    logic               score_clr;
    logic [16:0]        score_sum;
`endif

    function automatic logic counted(input logic [KIND_W-1:0] k);
        return (k != KIND_W'(KIND_EMPTY)) && (k != K_SOLID);
    endfunction

    function automatic logic [REM_W-1:0] row_pop(input row_t r);
        logic [REM_W-1:0] n;
        n = '0;
        for (int c = 0; c < int'(COLS); c++) n = n + REM_W'(counted(r[c]));
        return n;
    endfunction

    brick_stage_rom #(
        .ROWS   (ROWS),
        .COLS   (COLS),
        .KIND_W (KIND_W),
        .STAGES (STAGES)
    ) u_rom (
        .stage   (stage_q),
        .row     (cnt_q),
        .pattern (rom_row)
    );

    always_comb begin
        addr_ok  = (32'(row) < ROWS) && (32'(col) < COLS);
        cell_old = addr_ok ? grid[row][col] : '0;
    end

    // Next state, sweep control and single-cycle cell updates.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        stage_d     = stage_q;
        rem_d       = remaining;
        destroyed_d = 1'b0;
        cell_we     = 1'b0;
        cell_new    = cell_old;
        row_we      = 1'b0;
        row_idx     = cnt_q;
        row_data    = rom_row;
`ifdef GRID_SCORE_EN
        score_inc   = 4'd0;
        score_clr   = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                acc_d = '0;
                case (func)
                    FN_NOP: ;
                    FN_WRITE: begin
                        if (addr_ok) begin
                            cell_we  = 1'b1;
                            cell_new = in;
                            rem_d    = remaining + REM_W'(counted(in)) - REM_W'(counted(cell_old));
                        end
                    end
                    FN_HIT: begin
                        if (addr_ok && counted(cell_old)) begin
                            cell_we  = 1'b1;
                            cell_new = cell_old - KIND_W'(1);
`ifdef GRID_SCORE_EN
                            score_inc = 4'd1;
`endif
                            if (cell_old == KIND_W'(1)) begin
                                destroyed_d = 1'b1;
                                rem_d       = remaining - REM_W'(1);
`ifdef GRID_SCORE_EN
                                score_inc   = 4'd9;
`endif
                            end
                        end
                    end
                    FN_LOAD: begin
                        state_d = ST_LOAD;
                        stage_d = in;
`ifdef GRID_SCORE_EN
                        score_clr = 1'b1;
`endif
                    end
                    FN_DROP: state_d = ST_SHIFT_DN;
                    FN_PULL: state_d = ST_SHIFT_UP;
                    default: ;
                endcase
            end
            ST_LOAD: begin
                row_idx  = cnt_q;
                row_data = rom_row;
            end
            // Bottom-up so the source row above is still unmodified when copied.
            ST_SHIFT_DN: begin
                row_idx  = RW'(ROWS - 1) - cnt_q;
                row_data = (row_idx == '0) ? '0 : grid[row_idx - RW'(1)];
            end
            ST_SHIFT_UP: begin
                row_idx  = cnt_q;
                row_data = (cnt_q == RW'(ROWS - 1)) ? '0 : grid[cnt_q + RW'(1)];
            end
        endcase

        if (state_q != ST_IDLE) begin
            row_we = 1'b1;
            cnt_d  = cnt_q + RW'(1);
            acc_d  = acc_q + row_pop(row_data);
            if (cnt_q == RW'(ROWS - 1)) begin
                state_d = ST_IDLE;
                rem_d   = acc_d;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            stage_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            stage_q <= stage_d;
        end
    end

    // Field storage and registered outputs; out shows the cell before this cycle's update.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            grid      <= '0;
            out       <= '0;
            busy      <= 1'b0;
            remaining <= '0;
            destroyed <= 1'b0;
        end else begin
            if (cell_we) grid[row][col] <= cell_new;
            if (row_we)  grid[row_idx]  <= row_data;
            out       <= cell_old;
            busy      <= (state_d != ST_IDLE);
            remaining <= rem_d;
            destroyed <= destroyed_d;
        end
    end

`ifdef GRID_SCORE_EN
    assign score_sum = {1'b0, score} + 17'(score_inc);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            score <= '0;
        end else if (score_clr) begin
            score <= '0;
        end else begin
            score <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_brick_grid.sv
// Directed bench for brick_grid with hand-computed expectations (default parameters).
// Also covers the score output when GRID_SCORE_EN is defined.
module tb_brick_grid;

    localparam logic [3:0] F_NOP   = 4'b0000;
    localparam logic [3:0] F_WRITE = 4'b0011;
    localparam logic [3:0] F_LOAD  = 4'b0101;
    localparam logic [3:0] F_DROP  = 4'b0111;
    localparam logic [3:0] F_PULL  = 4'b1001;
    localparam logic [3:0] F_HIT   = 4'b1011;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] row   = '0;
    logic [3:0] col   = '0;
    logic [3:0] func  = F_NOP;
    logic [3:0] in    = '0;
    logic [3:0] out;
    logic       busy;
    logic [6:0] remaining;
    logic       destroyed;
`ifdef GRID_SCORE_EN
    logic [15:0] score;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    brick_grid #(
        .ROWS   (8),
        .COLS   (16),
        .KIND_W (4),
        .STAGES (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .row       (row),
        .col       (col),
        .func      (func),
        .in        (in),
        .out       (out),
        .busy      (busy),
        .remaining (remaining),
        .destroyed (destroyed)
`ifdef GRID_SCORE_EN
        ,
        .score     (score)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Called and returns at a falling edge; the command is sampled on the rising edge between.
    task automatic cmd(input logic [3:0] f, input int r, input int c, input int v);
        func = f;
        row  = 3'(r);
        col  = 4'(c);
        in   = 4'(v);
        @(posedge clock);
        @(negedge clock);
        func = F_NOP;
    endtask

    task automatic rd(input int r, input int c, output int v);
        cmd(F_NOP, r, c, 0);
        v = int'(out);
    endtask

    // Issue a sweep and count busy cycles; optionally hammer DROP while busy.
    task automatic sweep(input logic [3:0] f, input int v, input bit inject, output int n);
        logic seen;
        seen = 1'b0;
        n    = 0;
        cmd(f, 0, 0, v);
        while (busy && n < 40) begin
            n++;
            seen = seen | destroyed;
            func = (inject && n <= 3) ? F_DROP : F_NOP;
            @(negedge clock);
        end
        func = F_NOP;
        check("sweep_no_destroyed", 32'(seen), 0);
    endtask

    initial begin
        int v;
        int n;
        int pulses;

        // 1: reset
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rst_out", 32'(out), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_remaining", 32'(remaining), 0);
        check("rst_destroyed", 32'(destroyed), 0);

        // 2: LOAD stage 0 with an ignored DROP during the sweep
        sweep(F_LOAD, 0, 1'b1, n);
        check("load_busy_cycles", 32'(n), 8);
        check("load_remaining", 32'(remaining), 64);
        rd(0, 5, v);  check("load_r0c5", 32'(v), 1);
        rd(3, 0, v);  check("load_r3c0", 32'(v), 4);
        rd(4, 9, v);  check("load_r4c9_drop_ignored", 32'(v), 0);
        rd(7, 15, v); check("load_r7c15", 32'(v), 0);

        // 3: WRITE then five HITs down to empty
        cmd(F_WRITE, 7, 3, 5);
        check("write_remaining", 32'(remaining), 65);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            cmd(F_HIT, 7, 3, 0);
            check("hit_destroyed", 32'(destroyed), (i == 4) ? 1 : 0);
            pulses += int'(destroyed);
            rd(7, 3, v);
            check("hit_kind", 32'(v), 32'(4 - i));
            pulses += int'(destroyed);
        end
        check("hit_pulses", 32'(pulses), 1);
        check("hit_remaining", 32'(remaining), 64);

        // 4: indestructible brick
        cmd(F_WRITE, 7, 4, 15);
        check("solid_write_remaining", 32'(remaining), 64);
        cmd(F_HIT, 7, 4, 0);
        check("solid_hit_destroyed", 32'(destroyed), 0);
        rd(7, 4, v);  check("solid_kind", 32'(v), 15);
        check("solid_remaining", 32'(remaining), 64);
`ifdef GRID_SCORE_EN
        check("score_after_hits", 32'(score), 13);
`endif

        // Other stages: empty for out-of-range stage, offset kinds for stage 3
        sweep(F_LOAD, 5, 1'b0, n);
        check("load5_remaining", 32'(remaining), 0);
        rd(0, 0, v);  check("load5_r0c0", 32'(v), 0);
        sweep(F_LOAD, 3, 1'b0, n);
        rd(0, 2, v);  check("load3_r0c2", 32'(v), 4);
        rd(3, 11, v); check("load3_r3c11", 32'(v), 7);
        check("load3_remaining", 32'(remaining), 64);

        // 5: DROP / PULL
        sweep(F_LOAD, 0, 1'b0, n);
`ifdef GRID_SCORE_EN
        check("score_load_clear", 32'(score), 0);
`endif
        sweep(F_DROP, 0, 1'b0, n);
        check("drop_busy_cycles", 32'(n), 8);
        rd(4, 6, v);  check("drop_r4", 32'(v), 4);
        rd(1, 6, v);  check("drop_r1", 32'(v), 1);
        rd(0, 6, v);  check("drop_r0", 32'(v), 0);
        check("drop_remaining", 32'(remaining), 64);
        for (int i = 0; i < 4; i++) sweep(F_DROP, 0, 1'b0, n);
        check("drop5_remaining", 32'(remaining), 48);
        rd(7, 0, v);  check("drop5_r7", 32'(v), 3);
        rd(4, 0, v);  check("drop5_r4", 32'(v), 0);
        sweep(F_PULL, 0, 1'b0, n);
        check("pull_busy_cycles", 32'(n), 8);
        rd(6, 8, v);  check("pull_r6", 32'(v), 3);
        rd(7, 8, v);  check("pull_r7", 32'(v), 0);
        rd(4, 8, v);  check("pull_r4", 32'(v), 1);
        check("pull_remaining", 32'(remaining), 48);

        // 6: reset during the third cycle of a LOAD
        cmd(F_LOAD, 0, 0, 0);
        @(posedge clock);
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_remaining", 32'(remaining), 0);
        check("midrst_out", 32'(out), 0);
`ifdef GRID_SCORE_EN
        check("midrst_score", 32'(score), 0);
`endif
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("midrst_idle_busy", 32'(busy), 0);
        rd(0, 0, v);  check("midrst_r0", 32'(v), 0);
        rd(1, 7, v);  check("midrst_r1", 32'(v), 0);
        rd(6, 1, v);  check("midrst_r6", 32'(v), 0);
        cmd(F_WRITE, 2, 2, 9);
        check("midrst_write_accepted", 32'(remaining), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
